// File: rtl/qsfp_pkg.sv
// Shared types and constants for the QSFP Aurora link sequencer.
// Build option: QSFP_SOFT_ERR_COUNT_EN enables the per-channel soft-error counters.
package qsfp_pkg;

  localparam int RETRY_W = 8;
  localparam int SERR_W  = 16;

  typedef enum logic [1:0] {
    RST_ALL = 2'd0,
    RST_PB  = 2'd1,
    WAIT_UP = 2'd2,
    UP      = 2'd3
  } link_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qsfp_link_fsm.sv
// One channel's bring-up sequencer: reset FSM, phase timer, retry and soft-error counters.
// Build option: QSFP_SOFT_ERR_COUNT_EN builds the soft-error edge detect and counter.
module qsfp_link_fsm
  import qsfp_pkg::*;
#(
  parameter int LANE_COUNT = 4,
  parameter int PMA_CYCLES = 128,
  parameter int PB_HOLD    = 64,
  parameter int UP_TIMEOUT = 1_000_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  channel_up,
  input  logic [LANE_COUNT-1:0] lane_up,
  input  logic                  hard_err,
  input  logic                  soft_err,
  output logic                  pma_init,
  output logic                  reset_pb,
  output logic                  link_ready,
  output logic [RETRY_W-1:0]    retry_count,
  output logic [SERR_W-1:0]     soft_err_count,
  output link_state_e           state_o
);

  localparam int TW = $clog2(max3(PMA_CYCLES, PB_HOLD, UP_TIMEOUT)) + 1;
  localparam logic [TW-1:0] PMA_LAST = TW'(PMA_CYCLES - 1);
  localparam logic [TW-1:0] PB_LAST  = TW'(PB_HOLD - 1);
  localparam logic [TW-1:0] UP_LAST  = TW'(UP_TIMEOUT - 1);

  link_state_e        state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pma_init_q, pma_init_d;
  logic               reset_pb_q, reset_pb_d;
  logic               link_ready_q, link_ready_d;
  logic               retry_inc;
  logic               link_ok;

  assign link_ok = channel_up && (&lane_up);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    retry_inc = 1'b0;
    if (!enable) begin
      state_d = RST_ALL;
    end else begin
      case (state_q)
        RST_ALL: if (timer_q == PMA_LAST) state_d = RST_PB;
        RST_PB:  if (timer_q == PB_LAST) state_d = WAIT_UP;
        WAIT_UP: begin
          if (link_ok) begin
            state_d = UP;
          end else if ((timer_q == UP_LAST) || hard_err) begin
            // timeout and hard error together still count once
            state_d   = RST_ALL;
            retry_inc = 1'b1;
          end
        end
        UP: begin
          if (hard_err || !link_ok) begin
            state_d   = RST_ALL;
            retry_inc = 1'b1;
          end
        end
        default: state_d = RST_ALL;
      endcase
    end
    if ((state_d != state_q) || !enable) timer_d = '0;

    retry_d = retry_q;
    if (clear) retry_d = '0;
    else if (retry_inc && (retry_q != '1)) retry_d = retry_q + 1'b1;

    pma_init_d   = (state_d == RST_ALL);
    reset_pb_d   = (state_d == RST_ALL) || (state_d == RST_PB);
    link_ready_d = (state_d == UP);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= RST_ALL;
      timer_q      <= '0;
      retry_q      <= '0;
      pma_init_q   <= 1'b1;
      reset_pb_q   <= 1'b1;
      link_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      pma_init_q   <= pma_init_d;
      reset_pb_q   <= reset_pb_d;
      link_ready_q <= link_ready_d;
    end
  end

  assign pma_init    = pma_init_q;
  assign reset_pb    = reset_pb_q;
  assign link_ready  = link_ready_q;
  assign retry_count = retry_q;
  assign state_o     = state_q;

`ifdef QSFP_SOFT_ERR_COUNT_EN
  logic              soft_prev_q, soft_prev_d;
  logic [SERR_W-1:0] serr_q, serr_d;

  always_comb begin
    soft_prev_d = soft_err;
    serr_d      = serr_q;
    if (clear) serr_d = '0;
    else if ((state_q == UP) && soft_err && !soft_prev_q && (serr_q != '1)) serr_d = serr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      soft_prev_q <= 1'b0;
      serr_q      <= '0;
    end else begin
      soft_prev_q <= soft_prev_d;
      serr_q      <= serr_d;
    end
  end

  assign soft_err_count = serr_q;
`else
  logic soft_err_unused;
  assign soft_err_unused = soft_err;
  assign soft_err_count  = '0;
`endif

endmodule

// File: rtl/qsfp_link_sequencer.sv
// Per-channel Aurora bring-up/supervision for the QSFP cages; one qsfp_link_fsm per channel.
// Build option: QSFP_SOFT_ERR_COUNT_EN enables soft_err_count (otherwise tied to 0).
module qsfp_link_sequencer
  import qsfp_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int LANE_COUNT = 4,
  parameter int PMA_CYCLES = 128,
  parameter int PB_HOLD    = 64,
  parameter int UP_TIMEOUT = 1_000_000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            enable,
  input  logic                         clear,
  input  logic [NUM_CH-1:0]            channel_up,
  input  logic [NUM_CH*LANE_COUNT-1:0] lane_up,
  input  logic [NUM_CH-1:0]            hard_err,
  input  logic [NUM_CH-1:0]            soft_err,
  output logic [NUM_CH-1:0]            pma_init,
  output logic [NUM_CH-1:0]            reset_pb,
  output logic [NUM_CH-1:0]            link_ready,
  output logic [NUM_CH*RETRY_W-1:0]    retry_count,
  output logic [NUM_CH*SERR_W-1:0]     soft_err_count
);

  // per-channel state, left for checkers to probe
  link_state_e ch_state_unused [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    qsfp_link_fsm #(
      .LANE_COUNT (LANE_COUNT),
      .PMA_CYCLES (PMA_CYCLES),
      .PB_HOLD    (PB_HOLD),
      .UP_TIMEOUT (UP_TIMEOUT)
    ) u_fsm (
      .clk            (clk),
      .resetn         (resetn),
      .enable         (enable[c]),
      .clear          (clear),
      .channel_up     (channel_up[c]),
      .lane_up        (lane_up[c*LANE_COUNT +: LANE_COUNT]),
      .hard_err       (hard_err[c]),
      .soft_err       (soft_err[c]),
      .pma_init       (pma_init[c]),
      .reset_pb       (reset_pb[c]),
      .link_ready     (link_ready[c]),
      .retry_count    (retry_count[c*RETRY_W +: RETRY_W]),
      .soft_err_count (soft_err_count[c*SERR_W +: SERR_W]),
      .state_o        (ch_state_unused[c])
    );
  end

endmodule

// File: tb/tb_qsfp_link_sequencer.sv
// Scoreboard bench for qsfp_link_sequencer: directed bring-up/fault/counter cases, then random traffic.
module tb_qsfp_link_sequencer;

  localparam int NUM_CH     = 2;
  localparam int LANE_COUNT = 4;
  localparam int PMA_CYCLES = 16;
  localparam int PB_HOLD    = 8;
  localparam int UP_TIMEOUT = 100;
  localparam int OW         = 3*NUM_CH + NUM_CH*8 + NUM_CH*16;
`ifdef QSFP_SOFT_ERR_COUNT_EN
  localparam bit SERR_EN = 1'b1;
`else
  localparam bit SERR_EN = 1'b0;
`endif

  localparam int P_RST = 0, P_PB = 1, P_WAIT = 2, P_UP = 3;

  logic                         clk = 1'b0;
  logic                         resetn;
  logic [NUM_CH-1:0]            enable;
  logic                         clear;
  logic [NUM_CH-1:0]            channel_up;
  logic [NUM_CH*LANE_COUNT-1:0] lane_up;
  logic [NUM_CH-1:0]            hard_err;
  logic [NUM_CH-1:0]            soft_err;
  logic [NUM_CH-1:0]            pma_init;
  logic [NUM_CH-1:0]            reset_pb;
  logic [NUM_CH-1:0]            link_ready;
  logic [NUM_CH*8-1:0]          retry_count;
  logic [NUM_CH*16-1:0]         soft_err_count;

  // clock / reset block
  always #5 clk = ~clk;

  qsfp_link_sequencer #(
    .NUM_CH(NUM_CH), .LANE_COUNT(LANE_COUNT), .PMA_CYCLES(PMA_CYCLES),
    .PB_HOLD(PB_HOLD), .UP_TIMEOUT(UP_TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .channel_up(channel_up), .lane_up(lane_up), .hard_err(hard_err), .soft_err(soft_err),
    .pma_init(pma_init), .reset_pb(reset_pb), .link_ready(link_ready),
    .retry_count(retry_count), .soft_err_count(soft_err_count)
  );

  logic [OW-1:0] exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string tag = "reset";

  // reference model: phase of each channel and how long it has lasted
  int m_ph[NUM_CH];
  int m_age[NUM_CH];
  int m_retry[NUM_CH];
  int m_serr[NUM_CH];
  bit m_sprev[NUM_CH];
  int dur[3] = '{PMA_CYCLES, PB_HOLD, UP_TIMEOUT};

  task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic model_step();
    int  nph;
    bit  restart;
    bit  link_ok;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!resetn) begin
        m_ph[c] = P_RST; m_age[c] = 0; m_retry[c] = 0; m_serr[c] = 0; m_sprev[c] = 1'b0;
      end else begin
        link_ok = channel_up[c] && (&lane_up[c*LANE_COUNT +: LANE_COUNT]);
        restart = 1'b0;
        nph     = m_ph[c];
        if (!enable[c]) nph = P_RST;
        else if (m_ph[c] == P_UP) begin
          if (!link_ok || hard_err[c]) begin nph = P_RST; restart = 1'b1; end
        end else if (m_ph[c] == P_WAIT && link_ok) nph = P_UP;
        else if (m_ph[c] == P_WAIT && hard_err[c]) begin nph = P_RST; restart = 1'b1; end
        else if (m_age[c] + 1 == dur[m_ph[c]]) begin
          nph     = (m_ph[c] == P_WAIT) ? P_RST : m_ph[c] + 1;
          restart = (m_ph[c] == P_WAIT);
        end
        if (SERR_EN && m_ph[c] == P_UP && soft_err[c] && !m_sprev[c] && m_serr[c] < 65535)
          m_serr[c]++;
        m_sprev[c] = soft_err[c];
        if (restart && m_retry[c] < 255) m_retry[c]++;
        if (clear) begin m_retry[c] = 0; m_serr[c] = 0; end
        m_age[c] = (nph == m_ph[c] && enable[c]) ? m_age[c] + 1 : 0;
        m_ph[c]  = nph;
      end
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [NUM_CH-1:0]    p, b, r;
    logic [NUM_CH*8-1:0]  rc;
    logic [NUM_CH*16-1:0] sc;
    for (int c = 0; c < NUM_CH; c++) begin
      p[c] = (m_ph[c] == P_RST);
      b[c] = (m_ph[c] == P_RST) || (m_ph[c] == P_PB);
      r[c] = (m_ph[c] == P_UP);
      rc[c*8 +: 8]   = 8'(m_retry[c]);
      sc[c*16 +: 16] = 16'(m_serr[c]);
    end
    return {p, b, r, rc, sc};
  endfunction

  // driver: model sees the same inputs the DUT samples on the coming edge
  task automatic tick();
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // monitor: every edge presents a new output word
  initial begin : monitor
    logic [OW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_outputs"}, {pma_init, reset_pb, link_ready, retry_count, soft_err_count}, e);
      end
    end
  end

  initial begin : stimulus
    resetn = 1'b0; enable = '1; clear = 1'b0; channel_up = '0; lane_up = '0;
    hard_err = '0; soft_err = '0;
    idle(3);
    check("reset_pma", pma_init, 2'b11);
    check("reset_ready", link_ready, 2'b00);

    tag = "bringup";
    resetn = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      channel_up = (i >= 40) ? '1 : '0;
      lane_up    = (i >= 40) ? '1 : '0;
      tick();
      if (i == 15) check("pma_before_16", pma_init, 2'b11);
      if (i == 16) check("pma_fall_16", pma_init, 2'b00);
      if (i == 23) check("pb_before_24", reset_pb, 2'b11);
      if (i == 24) check("pb_fall_24", reset_pb, 2'b00);
      if (i == 39) check("ready_before_40", link_ready, 2'b00);
      if (i == 40) check("ready_rise_40", link_ready, 2'b11);
      if (i == 45) check("bringup_retry", retry_count, 16'h0000);
    end

    tag = "hard_err_up";
    hard_err = 2'b01;
    tick();
    hard_err = '0;
    check("hard_err_ready", link_ready, 2'b10);
    check("hard_err_pma", pma_init, 2'b01);
    check("hard_err_retry", retry_count, 16'h0001);
    idle(30);

    tag = "lane_drop";
    lane_up[2] = 1'b0;
    tick();
    lane_up = '1;
    check("lane_drop_ready", link_ready, 2'b10);
    check("lane_drop_pma", pma_init, 2'b01);
    check("lane_drop_retry", retry_count, 16'h0002);
    idle(30);

    tag = "soft_err";
    for (int k = 0; k < 3; k++) begin
      soft_err = '1; tick();
      soft_err = '0; tick();
    end
    check("soft_err_3", soft_err_count[15:0], SERR_EN ? 16'd3 : 16'd0);
    soft_err = '1;
    idle(10);
    soft_err = '0;
    tick();
    check("soft_err_held", soft_err_count, SERR_EN ? {16'd4, 16'd4} : 32'd0);

    tag = "enable";
    enable = 2'b01;
    tick();
    check("enable_ready", link_ready, 2'b01);
    check("enable_pma", pma_init, 2'b10);
    check("enable_retry", retry_count, 16'h0002);
    enable = '1;
    idle(30);

    // channel_up held low: drop at t=0, then a timeout every 124 edges
    tag = "timeout";
    channel_up = '0;
    for (int t = 0; t <= 37348; t++) begin
      hard_err = (t == 248) ? 2'b10 : 2'b00;
      clear    = (t == 37324);
      resetn   = (t != 37344);
      tick();
      if (t == 0)     check("drop_retry", retry_count[15:8], 8'd1);
      if (t == 123)   check("timeout1_pending", retry_count[15:8], 8'd1);
      if (t == 124)   check("timeout1", retry_count[15:8], 8'd2);
      if (t == 248)   check("timeout_and_herr", retry_count[15:8], 8'd3);
      if (t == 37323) check("retry_saturated", retry_count, 16'hffff);
      if (t == 37324) check("clear_wins", retry_count, 16'h0000);
      if (t == 37343) check("mid_rst_pb", {pma_init, reset_pb}, 4'b0011);
      if (t == 37344) check("mid_reset", {pma_init, reset_pb, link_ready, retry_count, soft_err_count},
                            {2'b11, 2'b11, 2'b00, 16'h0, 32'h0});
    end
    hard_err = '0; clear = 1'b0; resetn = 1'b1;

    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        enable[c]     = ($urandom_range(0, 199) != 0);
        channel_up[c] = ($urandom_range(0, 39) != 0);
        hard_err[c]   = ($urandom_range(0, 149) == 0);
        soft_err[c]   = $urandom_range(0, 1) != 0;
      end
      for (int l = 0; l < NUM_CH*LANE_COUNT; l++) lane_up[l] = ($urandom_range(0, 99) != 0);
      clear  = ($urandom_range(0, 299) == 0);
      resetn = ($urandom_range(0, 999) != 0);
      tick();
    end

    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qsfp_link_sequencer.md
# qsfp_link_sequencer

Brings up and supervises the Aurora links behind the two QSFP cages. One independent sequencer per channel drives the core's `pma_init` and `reset_pb`, waits for the link to come up, and restarts it on timeout, hard error or link drop. It sits between the board reset logic and the Aurora cores. Its status and counter outputs feed the QSFP status register block.

## Interface
Parameters:
- `NUM_CH`, 2: number of Aurora channels.
- `LANE_COUNT`, 4: lanes per channel.
- `PMA_CYCLES`, 128: clocks that `pma_init` and `reset_pb` are both held asserted.
- `PB_HOLD`, 64: clocks that `reset_pb` stays asserted after `pma_init` is released.
- `UP_TIMEOUT`, 1_000_000: clocks allowed in WAIT_UP before a retry.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `enable`  in  NUM_CH  per-channel run enable.
- `clear`  in  1  one-cycle pulse; zeroes all counters.
- `channel_up`  in  NUM_CH  Aurora channel_up.
- `lane_up`  in  NUM_CH*LANE_COUNT  lane_up; channel c uses bits [c*LANE_COUNT +: LANE_COUNT].
- `hard_err`  in  NUM_CH  Aurora hard_err.
- `soft_err`  in  NUM_CH  Aurora soft_err.
- `pma_init`  out  NUM_CH  to the Aurora core.
- `reset_pb`  out  NUM_CH  to the Aurora core.
- `link_ready`  out  NUM_CH  high while the channel is in UP.
- `retry_count`  out  NUM_CH*8  saturating restart count per channel.
- `soft_err_count`  out  NUM_CH*16  saturating soft-error count per channel.

## Operation
Per-channel states:
- **RST_ALL**:
  - `pma_init`=1, `reset_pb`=1.
  - Timer runs PMA_CYCLES clocks, then go to RST_PB.
  - While `enable[c]`=0: stay in RST_ALL with the timer held at 0.
- **RST_PB**:
  - `pma_init`=0, `reset_pb`=1.
  - After PB_HOLD clocks, go to WAIT_UP.
- **WAIT_UP**:
  - Both resets 0.
  - If `channel_up` is high and all lanes are up: go to UP.
  - Else if the timer reaches UP_TIMEOUT, or `hard_err` is high: go to RST_ALL and increment `retry_count`.
- **UP**:
  - `link_ready`=1.
  - If `hard_err` goes high, or `channel_up` drops, or any lane drops: go to RST_ALL and increment `retry_count`.

Common rules:
- `enable[c]` low in any state forces RST_ALL next cycle. This is not counted as a retry.
- Hard error and timeout in the same cycle count as one increment.
- Counters:
  - Saturate at 255 and 65535; never wrap.
  - `clear` wins over a simultaneous increment: the result is 0.
- `soft_err_count` increments on each rising edge of `soft_err`, detected with a registered previous value, counted only in UP.
- Timers are sized $clog2(max(PMA_CYCLES, PB_HOLD, UP_TIMEOUT))+1 bits. Each timer clears on every state entry.
- Channels are fully independent; there is no shared state except `clear`.

## Timing
- Reset values:
  - `pma_init`=all 1, `reset_pb`=all 1.
  - `link_ready`=0, all counters 0.
  - State RST_ALL, timers 0.
- All outputs are registered, decoded from the next state, so every output changes on the same edge as the state transition.
- Entry into RST_ALL to `pma_init` falling: exactly PMA_CYCLES clocks.
- `pma_init` falling to `reset_pb` falling: exactly PB_HOLD clocks.
- Link-up condition sampled in WAIT_UP at edge N: `link_ready`=1 after edge N.
- Fault sampled in UP at edge N: `link_ready`=0 and `pma_init`=1 after edge N; the counter update is visible after edge N.
- Mid-sequence reset: `resetn` low restores all reset values at the next edge, regardless of state.

## Configuration
- `QSFP_SOFT_ERR_COUNT_EN`:
  - Defined: soft-error edge detect and `soft_err_count` registers are built.
  - Undefined: `soft_err_count` is tied to 0, `soft_err` is ignored, and no registers are inferred.
- Sequencing and `retry_count` are identical in both builds.

## Structure
- Shared package `qsfp_pkg`:
  - State encoding localparams RST_ALL=0, RST_PB=1, WAIT_UP=2, UP=3.
  - Counter widths RETRY_W=8, SERR_W=16.
- Sub-module `qsfp_link_fsm`: one channel's FSM, timer and counters. The top generates NUM_CH instances and slices the vectors.

## Test plan
Bench parameters: PMA_CYCLES=16, PB_HOLD=8, UP_TIMEOUT=100.
- Normal bring-up: release reset, `enable`=1, drive `channel_up`/`lane_up`=1 at cycle 40 -> `pma_init` falls at cycle 16, `reset_pb` at 24, `link_ready` rises after the cycle-40 edge, `retry_count`=0.
- Timeout: `channel_up` held 0 -> RST_ALL re-entered 100 clocks after WAIT_UP entry, `retry_count`=1, then 2 after a second timeout.
- Fault in UP: pulse `hard_err` one cycle -> `link_ready`=0 and `pma_init`=1 the next edge, `retry_count`+1. Also drop `lane_up[2]` only -> same response.
- Counter edges:
  - 300 timeouts -> `retry_count` stays at 255.
  - `clear` coincident with an increment -> 0.
  - 3 `soft_err` pulses in UP -> `soft_err_count`=3 (0 when the macro is undefined).
  - `soft_err` held high 10 cycles -> count +1.
- Enable and reset: `enable[1]` low while UP -> ch1 to RST_ALL with no retry count, ch0 unaffected. `resetn` low mid-RST_PB -> all reset values restored on the next edge.
